// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: command word layout, FSM encoding and
// the saturating helper used by the optional grant statistics.
package mem_arbiter_pkg;

  localparam int CMD_W = 65;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WRITE = ST_WRITE,
    READ  = ST_READ
  } state_e;

  // Bit order matches the client/MIG command bus: {read, addr, length}.
  typedef struct packed {
    logic        read;
    logic [31:0] addr;
    logic [31:0] length;
  } mem_cmd_t;

  localparam logic [15:0] GRANT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == GRANT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin selector: searches upward from the port after last_grant_i and
// reports the first requester as one-hot plus index.
module rr_arbiter #(
  parameter int num_ports = 4,
  parameter int idx_w     = $clog2(num_ports)
) (
  input  logic [num_ports-1:0] req_i,
  input  logic [idx_w-1:0]     last_grant_i,
  output logic [num_ports-1:0] grant_o,
  output logic [idx_w-1:0]     grant_idx_o,
  output logic                 grant_valid_o
);

  function automatic logic [idx_w-1:0] rotate(input logic [idx_w-1:0] base, input int k);
    return idx_w'((int'(base) + k) % num_ports);
  endfunction

  // Scan farthest-first so the nearest requester after last_grant_i wins.
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = num_ports; k >= 1; k--) begin
      if (req_i[rotate(last_grant_i, k)]) begin
        grant_idx_o   = rotate(last_grant_i, k);
        grant_valid_o = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < num_ports; gi++) begin : g_onehot
    assign grant_o[gi] = grant_valid_o && (grant_idx_o == idx_w'(gi));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-client memory arbiter: round-robin command grant followed by an exclusive
// write or read data phase. Per-port grant counters are built with MEM_ARBITER_STATS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int mem_width = 32,
  parameter int len_width = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ports-1:0]           cl_cmd_valid,
  output logic [num_ports-1:0]           cl_cmd_ready,
  input  logic [num_ports*CMD_W-1:0]     cl_cmd,
  input  logic [num_ports*mem_width-1:0] cl_wr_data,
  input  logic [num_ports-1:0]           cl_wr_valid,
  output logic [num_ports-1:0]           cl_wr_ready,
  output logic [mem_width-1:0]           cl_rd_data,
  output logic [num_ports-1:0]           cl_rd_valid,
  input  logic [num_ports-1:0]           cl_rd_ready,
  output logic [CMD_W-1:0]               mem_cmd_data,
  output logic                           mem_cmd_valid,
  input  logic                           mem_cmd_ready,
  output logic [mem_width-1:0]           mem_write_data,
  output logic                           mem_write_valid,
  input  logic                           mem_write_ready,
  input  logic [mem_width-1:0]           mem_read_data,
  input  logic                           mem_read_valid,
  output logic                           mem_read_ready,
  output logic [num_ports*16-1:0]        grant_count
);

  localparam int IDX_W = $clog2(num_ports);

  mem_cmd_t             cl_cmd_arr  [num_ports];
  logic [mem_width-1:0] wr_data_arr [num_ports];

  for (genvar gi = 0; gi < num_ports; gi++) begin : g_unpack
    assign cl_cmd_arr[gi]  = mem_cmd_t'(cl_cmd[gi*CMD_W +: CMD_W]);
    assign wr_data_arr[gi] = cl_wr_data[gi*mem_width +: mem_width];
  end

  state_e               state_q, state_d;
  mem_cmd_t             cmd_q, cmd_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [len_width-1:0] beat_q, beat_d;

  logic [num_ports-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [len_width-1:0] arb_len;
  logic [len_width-1:0] len_q;
  logic                 last_beat;
  logic                 wr_fire;
  logic                 rd_fire;

  rr_arbiter #(
    .num_ports (num_ports),
    .idx_w     (IDX_W)
  ) u_rr (
    .req_i         (cl_cmd_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  assign arb_len   = len_width'(cl_cmd_arr[arb_idx].length);
  assign len_q     = len_width'(cmd_q.length);
  // Comparing against length-1 lets the largest length finish without the counter wrapping.
  assign last_beat = (beat_q == len_q - len_width'(1));
  assign wr_fire   = mem_write_valid && mem_write_ready;
  assign rd_fire   = mem_read_valid && mem_read_ready;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          cmd_d        = cl_cmd_arr[arb_idx];
          gnt_d        = arb_idx;
          last_grant_d = arb_idx;
          beat_d       = '0;
          // Zero-length commands are consumed here and never reach the MIG side.
          if (arb_len != '0) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_cmd_ready) begin
          state_d = cmd_q.read ? READ : WRITE;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + len_width'(1);
          end
        end
      end
      READ: begin
        if (rd_fire) begin
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + len_width'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      gnt_q        <= '0;
      last_grant_q <= IDX_W'(num_ports - 1);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

  assign mem_cmd_data   = cmd_q;
  assign mem_write_data = wr_data_arr[gnt_q];
  assign cl_rd_data     = mem_read_data;

  // Handshake outputs are gated by reset so nothing can complete while it is held.
  always_comb begin
    cl_cmd_ready    = '0;
    cl_wr_ready     = '0;
    cl_rd_valid     = '0;
    mem_cmd_valid   = 1'b0;
    mem_write_valid = 1'b0;
    mem_read_ready  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:  cl_cmd_ready = arb_grant;
        ISSUE: mem_cmd_valid = 1'b1;
        WRITE: begin
          mem_write_valid    = cl_wr_valid[gnt_q];
          cl_wr_ready[gnt_q] = mem_write_ready;
        end
        READ: begin
          cl_rd_valid[gnt_q] = mem_read_valid;
          mem_read_ready     = cl_rd_ready[gnt_q];
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic cmd_fire;
  assign cmd_fire = mem_cmd_valid && mem_cmd_ready;

  for (genvar gi = 0; gi < num_ports; gi++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (cmd_fire && (gnt_q == IDX_W'(gi))) begin
        cnt_q <= sat_inc16(cnt_q);
      end
    end
    assign grant_count[gi*16 +: 16] = cnt_q;
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scripted clients and an always-ready MIG side,
// with transfers logged mid-cycle and compared against hand-computed values.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int MW = 32;
  localparam int LW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     cl_cmd_valid, cl_cmd_ready;
  logic [NP*65-1:0]  cl_cmd;
  logic [NP*MW-1:0]  cl_wr_data;
  logic [NP-1:0]     cl_wr_valid, cl_wr_ready;
  logic [MW-1:0]     cl_rd_data;
  logic [NP-1:0]     cl_rd_valid, cl_rd_ready;
  logic [64:0]       mem_cmd_data;
  logic              mem_cmd_valid, mem_cmd_ready;
  logic [MW-1:0]     mem_write_data;
  logic              mem_write_valid, mem_write_ready;
  logic [MW-1:0]     mem_read_data;
  logic              mem_read_valid, mem_read_ready;
  logic [NP*16-1:0]  grant_count;

  mem_arbiter #(.num_ports(NP), .mem_width(MW), .len_width(LW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cl_cmd_valid    (cl_cmd_valid),
    .cl_cmd_ready    (cl_cmd_ready),
    .cl_cmd          (cl_cmd),
    .cl_wr_data      (cl_wr_data),
    .cl_wr_valid     (cl_wr_valid),
    .cl_wr_ready     (cl_wr_ready),
    .cl_rd_data      (cl_rd_data),
    .cl_rd_valid     (cl_rd_valid),
    .cl_rd_ready     (cl_rd_ready),
    .mem_cmd_data    (mem_cmd_data),
    .mem_cmd_valid   (mem_cmd_valid),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_write_data  (mem_write_data),
    .mem_write_valid (mem_write_valid),
    .mem_write_ready (mem_write_ready),
    .mem_read_data   (mem_read_data),
    .mem_read_valid  (mem_read_valid),
    .mem_read_ready  (mem_read_ready),
    .grant_count     (grant_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  mem_cmd_t      port_cmd  [NP];
  int            cmds_left [NP];
  logic [MW-1:0] wr_words  [NP][8];
  int            wr_idx    [NP];
  logic [MW-1:0] rd_words  [8];
  int            rd_idx;

  mem_cmd_t      cmd_log[$];
  logic [MW-1:0] wr_log[$];
  logic [MW-1:0] rd_log[$];
  int            rd_port_log[$];
  logic [NP-1:0] rd_valid_seen;
  logic          last_mrr;
  int            cyc;
  int            first_acc_cyc;
  int            first_cmd_cyc;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      cl_cmd_valid[p]        = (cmds_left[p] > 0);
      cl_cmd[p*65 +: 65]     = port_cmd[p];
      cl_wr_data[p*MW +: MW] = wr_words[p][wr_idx[p] % 8];
    end
    mem_read_data = rd_words[rd_idx % 8];
  endtask

  // Sample at the falling edge, let the rising edge commit, then advance the client models.
  task automatic tick();
    logic [NP-1:0] acc, wacc;
    logic          racc;
    @(negedge clk);
    if (cl_cmd_ready != '0 && first_acc_cyc < 0) first_acc_cyc = cyc;
    if (mem_cmd_valid && mem_cmd_ready) begin
      cmd_log.push_back(mem_cmd_t'(mem_cmd_data));
      if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
      $display("cyc %0d mem_cmd read=%0d addr=%h len=%0d", cyc,
               mem_cmd_data[64], mem_cmd_data[63:32], mem_cmd_data[31:0]);
    end
    if (mem_write_valid && mem_write_ready) wr_log.push_back(mem_write_data);
    rd_valid_seen = rd_valid_seen | cl_rd_valid;
    last_mrr      = mem_read_ready;
    for (int p = 0; p < NP; p++) begin
      if (cl_rd_valid[p] && cl_rd_ready[p]) begin
        rd_log.push_back(cl_rd_data);
        rd_port_log.push_back(p);
      end
    end
    acc  = cl_cmd_valid & cl_cmd_ready;
    wacc = cl_wr_valid & cl_wr_ready;
    racc = mem_read_valid && mem_read_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (acc[p])  cmds_left[p]--;
      if (wacc[p]) wr_idx[p]++;
    end
    if (racc) rd_idx++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    wr_log.delete();
    rd_log.delete();
    rd_port_log.delete();
    rd_valid_seen = '0;
    first_acc_cyc = -1;
    first_cmd_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      cmds_left[p] = 0;
      wr_idx[p]    = 0;
      port_cmd[p]  = '0;
      for (int i = 0; i < 8; i++) wr_words[p][i] = '0;
    end
    for (int i = 0; i < 8; i++) rd_words[i] = '0;
    rd_idx          = 0;
    cl_wr_valid     = '0;
    cl_rd_ready     = '0;
    mem_cmd_ready   = 1'b1;
    mem_write_ready = 1'b1;
    mem_read_valid  = 1'b0;
    clear_logs();
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] pat;
    cyc = 0;
    reset = 1'b1;
    do_reset();

    // Reset state
    check_val("rst_state", dut.state_q, IDLE);
    check_val("rst_last_grant", dut.last_grant_q, 3);
    check_val("rst_grant_count", grant_count, 0);
    check_val("rst_handshakes", {cl_cmd_ready, cl_wr_ready, cl_rd_valid, mem_cmd_valid}, 0);

    // Port 2 write of four words A..D to 0x100
    port_cmd[2] = '{read: 1'b0, addr: 32'h100, length: 32'd4};
    wr_words[2][0] = 32'hA; wr_words[2][1] = 32'hB;
    wr_words[2][2] = 32'hC; wr_words[2][3] = 32'hD;
    cmds_left[2] = 1;
    cl_wr_valid  = '1;
    drive_inputs();
    run(12);
    check_val("wr_cmd_count", cmd_log.size(), 1);
    check_val("wr_cmd", cmd_log[0], {1'b0, 32'h100, 32'd4});
    check_val("wr_cmd_latency", first_cmd_cyc - first_acc_cyc, 1);
    check_val("wr_beats", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("wr_word%0d", i), wr_log[i], 32'hA + i);
    check_val("wr_end_state", dut.state_q, IDLE);

    // All four ports at once, port 0 holding a second command
    do_reset();
    for (int p = 0; p < NP; p++) begin
      port_cmd[p]  = '{read: 1'b0, addr: 32'h1000 + 32'(p) * 32'h10, length: 32'd1};
      cmds_left[p] = 1;
      for (int i = 0; i < 8; i++) wr_words[p][i] = 32'(p * 16 + i);
    end
    cmds_left[0] = 2;
    cl_wr_valid  = '1;
    drive_inputs();
    run(30);
    check_val("rr_cmd_count", cmd_log.size(), 5);
    check_val("rr_order0", cmd_log[0].addr, 32'h1000);
    check_val("rr_order1", cmd_log[1].addr, 32'h1010);
    check_val("rr_order2", cmd_log[2].addr, 32'h1020);
    check_val("rr_order3", cmd_log[3].addr, 32'h1030);
    check_val("rr_order4", cmd_log[4].addr, 32'h1000);
    check_val("rr_wr_data", {wr_log[0], wr_log[1], wr_log[4]}, {32'h0, 32'h10, 32'h1});

    // Port 1 read of three words with a toggling client ready
    do_reset();
    port_cmd[1] = '{read: 1'b1, addr: 32'h200, length: 32'd3};
    rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33;
    cmds_left[1]   = 1;
    mem_read_valid = 1'b1;
    drive_inputs();
    for (int i = 0; i < 10 && cmd_log.size() == 0; i++) tick();
    check_val("rd_cmd", cmd_log[0], {1'b1, 32'h200, 32'd3});
    pat = '0;
    for (int k = 0; k < 5; k++) begin
      pat[1]      = ~k[0];
      cl_rd_ready = pat;
      tick();
      check_val($sformatf("rd_mirror%0d", k), last_mrr, pat[1]);
    end
    cl_rd_ready = '0;
    run(2);
    check_val("rd_count", rd_log.size(), 3);
    check_val("rd_data", {rd_log[0], rd_log[1], rd_log[2]}, {32'h11, 32'h22, 32'h33});
    check_val("rd_ports", {rd_port_log[0], rd_port_log[1], rd_port_log[2]}, {32'd1, 32'd1, 32'd1});
    check_val("rd_valid_only_p1", rd_valid_seen, 4'b0010);
    check_val("rd_end_state", dut.state_q, IDLE);

    // Zero-length command on port 0 with port 1 waiting
    do_reset();
    port_cmd[0] = '{read: 1'b0, addr: 32'h400, length: 32'd0};
    port_cmd[1] = '{read: 1'b0, addr: 32'h500, length: 32'd1};
    wr_words[1][0] = 32'h55;
    cmds_left[0] = 1;
    cmds_left[1] = 1;
    cl_wr_valid  = '1;
    drive_inputs();
    run(10);
    check_val("len0_consumed", cmds_left[0], 0);
    check_val("len0_cmd_count", cmd_log.size(), 1);
    check_val("len0_next_addr", cmd_log[0].addr, 32'h500);
    check_val("len0_last_grant", dut.last_grant_q, 1);

    // Reset during an 8-word write after the second beat
    do_reset();
    port_cmd[2] = '{read: 1'b0, addr: 32'h600, length: 32'd8};
    for (int i = 0; i < 8; i++) wr_words[2][i] = 32'hB0 + 32'(i);
    cmds_left[2] = 1;
    cl_wr_valid  = '1;
    drive_inputs();
    for (int i = 0; i < 20 && wr_log.size() < 2; i++) tick();
    check_val("mid_rst_beats", wr_log.size(), 2);
    reset = 1'b1;
    port_cmd[1] = '{read: 1'b0, addr: 32'h700, length: 32'd2};
    wr_words[1][0] = 32'hC0; wr_words[1][1] = 32'hC1;
    wr_idx[1]    = 0;
    cmds_left[1] = 1;
    mem_read_valid = 1'b1;
    cl_rd_ready    = '1;
    clear_logs();
    drive_inputs();
    @(negedge clk);
    check_val("mid_rst_outs", {cl_cmd_ready, cl_wr_ready, cl_rd_valid,
                               mem_cmd_valid, mem_write_valid, mem_read_ready}, 0);
    check_val("mid_rst_state", dut.state_q, IDLE);
    check_val("mid_rst_beat", dut.beat_q, 0);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    mem_read_valid = 1'b0;
    cl_rd_ready    = '0;
    drive_inputs();
    run(10);
    check_val("post_rst_cmd_count", cmd_log.size(), 1);
    check_val("post_rst_cmd", cmd_log[0], {1'b0, 32'h700, 32'd2});
    check_val("post_rst_data", {32'(wr_log.size()), wr_log[0], wr_log[1]}, {32'd2, 32'hC0, 32'hC1});

    // Five grants on port 3 for the statistics counters
    do_reset();
    port_cmd[3] = '{read: 1'b0, addr: 32'h800, length: 32'd1};
    for (int i = 0; i < 8; i++) wr_words[3][i] = 32'hD0 + 32'(i);
    cmds_left[3] = 5;
    cl_wr_valid  = '1;
    drive_inputs();
    run(25);
    check_val("stat_cmd_count", cmd_log.size(), 5);
    for (int p = 0; p < NP; p++) begin
`ifdef MEM_ARBITER_STATS_EN
      check_val($sformatf("stat_gc%0d", p), grant_count[p*16 +: 16], (p == 3) ? 16'd5 : 16'd0);
`else
      check_val($sformatf("stat_gc%0d", p), grant_count[p*16 +: 16], 16'd0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
